local_mem_ch_mon: RTL and testbench

LOCAL_MEM_CH_MON -- requirements
Module: local_mem_ch_mon

---
 rtl/local_mem_ch_mon_pkg.sv | 17 +
 rtl/local_mem_ch_fsm.sv | 110 +++++++++++
 rtl/local_mem_ch_mon.sv | 75 +++++++
 tb/tb_local_mem_ch_mon.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/local_mem_ch_mon_pkg.sv
// Shared types and constants for the local memory channel calibration monitor.
package local_mem_ch_mon_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned RST_PULSE_LEN = 16;
    localparam int unsigned PULSE_W       = $clog2(RST_PULSE_LEN);
    localparam int unsigned RETRY_W       = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_READY    = 3'd2,
        ST_FAIL     = 3'd3,
        ST_TIMEOUT  = 3'd4
    } ch_state_e;

endpackage

// File: rtl/local_mem_ch_fsm.sv
// Calibration tracker for one memory channel: reset pulse, timeout and result states.
// Optional retry from FAIL/TIMEOUT is enabled by LOCAL_MEM_CH_MON_RETRY_EN.
module local_mem_ch_fsm
    import local_mem_ch_mon_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enable,
    input  logic      cal_success,
    input  logic      cal_fail,
    input  logic      retry_req,
    output logic      rst_req,
    output logic      ready,
    output ch_state_e state,
    output ch_state_e state_nxt_c
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
    ,
    output logic [RETRY_W-1:0] retry_cnt
`endif
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]   cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               cal_ok;
    logic               cal_bad;
    logic               start_cal;

    // Calibration results are meaningless while the EMIF is still held in reset.
    assign cal_ok  = cal_success && !rst_req;
    assign cal_bad = cal_fail && !rst_req;

    always_comb begin
        state_nxt_c = state;
        start_cal   = 1'b0;
        if (!enable) begin
            state_nxt_c = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt_c = ST_WAIT_CAL;
                    start_cal   = 1'b1;
                end
                ST_WAIT_CAL: begin
                    if (cal_bad)               state_nxt_c = ST_FAIL;
                    else if (cal_ok)           state_nxt_c = ST_READY;
                    else if (cnt == CNT_LAST)  state_nxt_c = ST_TIMEOUT;
                end
                ST_READY: begin
                    if (!cal_success || cal_fail) state_nxt_c = ST_FAIL;
                end
                ST_FAIL, ST_TIMEOUT: begin
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
                    if (retry_req && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                        state_nxt_c = ST_WAIT_CAL;
                        start_cal   = 1'b1;
                    end
`else
                    state_nxt_c = state;
`endif
                end
                default: state_nxt_c = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            rst_req   <= 1'b0;
            cnt       <= '0;
            pulse_cnt <= '0;
        end else begin
            state <= state_nxt_c;
            ready <= (state_nxt_c == ST_READY);
            if (start_cal) begin
                cnt       <= '0;
                rst_req   <= 1'b1;
                pulse_cnt <= PULSE_W'(RST_PULSE_LEN - 1);
            end else begin
                if ((state == ST_WAIT_CAL) && (cnt != '1)) cnt <= cnt + CNT_W'(1);
                if (state_nxt_c != ST_WAIT_CAL) begin
                    rst_req <= 1'b0;
                end else if (rst_req) begin
                    if (pulse_cnt == '0) rst_req <= 1'b0;
                    else                 pulse_cnt <= pulse_cnt - PULSE_W'(1);
                end
            end
        end
    end

`ifdef LOCAL_MEM_CH_MON_RETRY_EN
    // Retry budget is only restored by going through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          retry_cnt <= '0;
        else if (state_nxt_c == ST_IDLE)     retry_cnt <= '0;
        else if (start_cal && (state != ST_IDLE)) retry_cnt <= retry_cnt + RETRY_W'(1);
    end
`else
    logic unused_retry;
    assign unused_retry = retry_req & (MAX_RETRY != 0);
`endif

endmodule

// File: rtl/local_mem_ch_mon.sv
// Multi-channel EMIF calibration monitor with aggregate ready/error flags.
// Define LOCAL_MEM_CH_MON_RETRY_EN to allow CSR retries and expose retry_cnt.
module local_mem_ch_mon
    import local_mem_ch_mon_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         cal_success,
    input  logic [NUM_CH-1:0]         cal_fail,
    input  logic [NUM_CH-1:0]         retry_req,
    output logic [NUM_CH-1:0]         ch_rst_req,
    output logic [STATE_W*NUM_CH-1:0] ch_state,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic                      all_ready,
    output logic                      any_error
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
    ,
    output logic [RETRY_W*NUM_CH-1:0] retry_cnt
`endif
);

    ch_state_e state_q   [NUM_CH];
    ch_state_e state_nxt [NUM_CH];
    logic      all_ready_c;
    logic      any_error_c;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        local_mem_ch_fsm #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .MAX_RETRY      (MAX_RETRY)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (ch_enable[gi]),
            .cal_success (cal_success[gi]),
            .cal_fail    (cal_fail[gi]),
            .retry_req   (retry_req[gi]),
            .rst_req     (ch_rst_req[gi]),
            .ready       (ch_ready[gi]),
            .state       (state_q[gi]),
            .state_nxt_c (state_nxt[gi])
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
            ,
            .retry_cnt   (retry_cnt[gi*RETRY_W +: RETRY_W])
`endif
        );
        assign ch_state[gi*STATE_W +: STATE_W] = state_q[gi];
    end

    // Aggregates are formed from next states so they line up with the per-channel registers.
    always_comb begin
        all_ready_c = |ch_enable;
        any_error_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_enable[i] && (state_nxt[i] != ST_READY)) all_ready_c = 1'b0;
            if ((state_nxt[i] == ST_FAIL) || (state_nxt[i] == ST_TIMEOUT)) any_error_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ready <= 1'b0;
            any_error <= 1'b0;
        end else begin
            all_ready <= all_ready_c;
            any_error <= any_error_c;
        end
    end

endmodule

// File: tb/tb_local_mem_ch_mon.sv
// Self-checking bench for local_mem_ch_mon: directed vectors, corner sequences, random vs model.
module tb_local_mem_ch_mon;

    localparam int NCH  = 4;
    localparam int TO   = 64;
    localparam int MAXR = 2;
    localparam int M_IDLE = 0, M_WAIT = 1, M_READY = 2, M_FAIL = 3, M_TIMEOUT = 4;
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_enable, cal_success, cal_fail, retry_req;
    logic [3:0]  ch_rst_req, ch_ready;
    logic [11:0] ch_state;
    logic        all_ready, any_error;
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
    logic [15:0] retry_cnt;
`endif

    local_mem_ch_mon #(.NUM_CH(NCH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_enable   (ch_enable),
        .cal_success (cal_success),
        .cal_fail    (cal_fail),
        .retry_req   (retry_req),
        .ch_rst_req  (ch_rst_req),
        .ch_state    (ch_state),
        .ch_ready    (ch_ready),
        .all_ready   (all_ready),
        .any_error   (any_error)
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
        ,
        .retry_cnt   (retry_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: channel state, cycles spent in WAIT_CAL, retries used.
    int   m_st  [NCH];
    int   m_age [NCH];
    int   m_rty [NCH];
    logic m_all, m_err;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_st[i] = M_IDLE; m_age[i] = 0; m_rty[i] = 0;
        end
        m_all = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        bit pulse;
        bit all_ok;
        for (int i = 0; i < NCH; i++) begin
            pulse = (m_st[i] == M_WAIT) && (m_age[i] < 16);
            if (!ch_enable[i]) begin
                m_st[i] = M_IDLE; m_rty[i] = 0;
            end else begin
                case (m_st[i])
                    M_IDLE: begin m_st[i] = M_WAIT; m_age[i] = 0; end
                    M_WAIT: begin
                        if (!pulse && cal_fail[i])         m_st[i] = M_FAIL;
                        else if (!pulse && cal_success[i]) m_st[i] = M_READY;
                        else if (m_age[i] == TO - 1)       m_st[i] = M_TIMEOUT;
                        else                               m_age[i]++;
                    end
                    M_READY: if (!cal_success[i] || cal_fail[i]) m_st[i] = M_FAIL;
                    default: begin
                        if (RETRY_ON && retry_req[i] && (m_rty[i] < MAXR)) begin
                            m_st[i] = M_WAIT; m_age[i] = 0; m_rty[i]++;
                        end
                    end
                endcase
            end
        end
        m_err  = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (m_st[i] == M_FAIL || m_st[i] == M_TIMEOUT) m_err = 1'b1;
            if (ch_enable[i] && m_st[i] != M_READY) all_ok = 1'b0;
        end
        m_all = (|ch_enable) && all_ok;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [11:0] es;
        logic [3:0]  er, et;
        logic [15:0] ec;
        for (int i = 0; i < NCH; i++) begin
            es[i*3 +: 3] = 3'(m_st[i]);
            er[i]        = (m_st[i] == M_READY);
            et[i]        = (m_st[i] == M_WAIT) && (m_age[i] < 16);
            ec[i*4 +: 4] = 4'(m_rty[i]);
        end
        chk({tag, ".ch_state"},   32'(ch_state),   32'(es));
        chk({tag, ".ch_ready"},   32'(ch_ready),   32'(er));
        chk({tag, ".ch_rst_req"}, 32'(ch_rst_req), 32'(et));
        chk({tag, ".all_ready"},  32'(all_ready),  32'(m_all));
        chk({tag, ".any_error"},  32'(any_error),  32'(m_err));
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
        chk({tag, ".retry_cnt"},  32'(retry_cnt),  32'(ec));
`else
        if (ec != 16'h0) chk({tag, ".model_retry"}, 32'(ec), 32'h0);
`endif
    endtask

    task automatic run(input logic [3:0] en, input logic [3:0] s, input logic [3:0] f,
                       input logic [3:0] r, input int n, input string tag);
        ch_enable = en; cal_success = s; cal_fail = f; retry_req = r;
        for (int k = 0; k < n; k++) begin
            tick();
            check_all(tag);
        end
        retry_req = 4'h0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ch_state"},   32'(ch_state),   32'h0);
        chk({tag, ".ch_ready"},   32'(ch_ready),   32'h0);
        chk({tag, ".ch_rst_req"}, 32'(ch_rst_req), 32'h0);
        chk({tag, ".all_ready"},  32'(all_ready),  32'h0);
        chk({tag, ".any_error"},  32'(any_error),  32'h0);
    endtask

    typedef struct {
        logic [3:0]  en, s, f;
        int          hold;
        logic [11:0] st;
        logic [3:0]  rdy, rst;
        logic        all, err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{4'h1, 4'h0, 4'h0,  1, 12'h001, 4'h0, 4'h1, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 4'h1, 4'h0, 15, 12'h001, 4'h0, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{4'h1, 4'h1, 4'h0,  1, 12'h001, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[3]  = '{4'h1, 4'h1, 4'h0,  1, 12'h002, 4'h1, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{4'h1, 4'h0, 4'h0,  1, 12'h003, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[5]  = '{4'h0, 4'h0, 4'h0,  1, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{4'h2, 4'h0, 4'h0, 64, 12'h008, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[7]  = '{4'h2, 4'h0, 4'h0,  1, 12'h020, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[8]  = '{4'h2, 4'h0, 4'h0,  5, 12'h020, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[9]  = '{4'h3, 4'h0, 4'h0, 17, 12'h021, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{4'h3, 4'h1, 4'h1,  1, 12'h023, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{4'h0, 4'h0, 4'h0,  1, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[12] = '{4'h8, 4'h0, 4'h0, 17, 12'h200, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[13] = '{4'h8, 4'h8, 4'h0,  1, 12'h400, 4'h8, 4'h0, 1'b1, 1'b0};
        vecs[14] = '{4'h0, 4'h8, 4'h0,  1, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0};

        rst_n = 1'b0;
        ch_enable = 4'h0; cal_success = 4'h0; cal_fail = 4'h0; retry_req = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Directed vectors from a clean start.
        for (int v = 0; v < 15; v++) begin
            ch_enable = vecs[v].en; cal_success = vecs[v].s; cal_fail = vecs[v].f;
            for (int k = 0; k < vecs[v].hold; k++) tick();
            chk($sformatf("vec%0d.ch_state", v),   32'(ch_state),   32'(vecs[v].st));
            chk($sformatf("vec%0d.ch_ready", v),   32'(ch_ready),   32'(vecs[v].rdy));
            chk($sformatf("vec%0d.ch_rst_req", v), 32'(ch_rst_req), 32'(vecs[v].rst));
            chk($sformatf("vec%0d.all_ready", v),  32'(all_ready),  32'(vecs[v].all));
            chk($sformatf("vec%0d.any_error", v),  32'(any_error),  32'(vecs[v].err));
        end

        // Channel 2 fails, then three retry pulses with a budget of two.
        run(4'h4, 4'h0, 4'h4, 4'h0, 18, "fail2");
        chk("fail2.state", 32'(ch_state[8:6]), 32'(M_FAIL));
        for (int k = 0; k < 3; k++) begin
            run(4'h4, 4'h0, 4'h4, 4'h4, 1, "retry");
            chk($sformatf("retry%0d.state", k), 32'(ch_state[8:6]),
                (RETRY_ON && k < 2) ? 32'(M_WAIT) : 32'(M_FAIL));
            run(4'h4, 4'h0, 4'h4, 4'h0, 18, "refail");
        end
        chk("retry_end.state", 32'(ch_state[8:6]), 32'(M_FAIL));
`ifdef LOCAL_MEM_CH_MON_RETRY_EN
        chk("retry_end.retry_cnt", 32'(retry_cnt[11:8]), 32'd2);
`endif
        run(4'h0, 4'h0, 4'h0, 4'h0, 1, "idle");

        // Asynchronous reset in the middle of WAIT_CAL, then restart from IDLE.
        run(4'hf, 4'h0, 4'h0, 4'h0, 5, "prerst");
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(4'hf, 4'h0, 4'h0, 4'h0, 1, "restart");
        chk("restart.ch_state", 32'(ch_state), 32'h249);
        chk("restart.ch_rst_req", 32'(ch_rst_req), 32'hf);

        // Randomized level stimulus against the reference model.
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(149) == 0) ch_enable[i]   = ~ch_enable[i];
                if ($urandom_range(24) == 0)  cal_success[i] = ~cal_success[i];
                if ($urandom_range(59) == 0)  cal_fail[i]    = ~cal_fail[i];
                retry_req[i] = ($urandom_range(7) == 0);
            end
            tick();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
